// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types. Holds the M-extension op encodings,
// the multiply/divide FSM states and the execution-unit routing indices.
package riscv_pkg;

  // Execution units that decode can route an instruction to.
  localparam int NB_UNIT     = 5;
  localparam int UNIT_ALU    = 0;
  localparam int UNIT_BRU    = 1;
  localparam int UNIT_LSU    = 2;
  localparam int UNIT_CSR    = 3;
  localparam int UNIT_MULDIV = 4;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_CALC = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic md_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_rs1_signed(input muldiv_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_rs2_signed(input muldiv_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the {hi,lo} accumulator.
// Ports: is_div_i selects restore-subtract, acc_i/opnd_i in, acc_o out.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    // multiply: add multiplicand on lo[0], then shift the pair right
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]}
           + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // divide: partial remainder shifted left with next dividend bit
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      // no borrow means the divisor fits: keep difference, quotient bit 1
      if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else             acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit (IDLE/PREP/CALC/FIX/DONE).
// In: start_v_i/op_i/rs1/rs2/rd_adr_i/flush_i. Out: ready/busy, res_v/data/rd.
module exe_muldiv import riscv_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_v_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_adr_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            res_v_o,
  output logic [XLEN-1:0] res_data_o,
  output logic [4:0]      res_rd_adr_o
);

  localparam int NSTEP = XLEN / UNROLL;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              neg_q, neg_d;
  logic              fast_q, fast_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        tag_q, tag_d;

  logic              accept;
  logic [XLEN-1:0]   rs1_p, rs2_p, abs1, abs2;
  logic              neg1, neg2, ovf, prep_fast;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res_fix;
  logic              dz;

  logic [UNROLL:0][2*XLEN-1:0] chain;

  assign chain[0] = acc_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (md_is_div(op_q)),
      .acc_i    (chain[i]),
      .opnd_i   (opnd_q),
      .acc_o    (chain[i+1])
    );
  end

  assign accept = (state_q == MD_IDLE) & start_v_i & ~flush_i;

  // PREP: raw operands sit in acc_q as {rs1, rs2}
  always_comb begin : prep_c
    rs1_p     = acc_q[2*XLEN-1:XLEN];
    rs2_p     = acc_q[XLEN-1:0];
    neg1      = md_rs1_signed(op_q) & rs1_p[XLEN-1];
    neg2      = md_rs2_signed(op_q) & rs2_p[XLEN-1];
    abs1      = neg1 ? -rs1_p : rs1_p;
    abs2      = neg2 ? -rs2_p : rs2_p;
    ovf       = md_is_div(op_q) & md_rs2_signed(op_q)
              & (rs1_p == MIN_NEG) & (&rs2_p);
    prep_fast = md_is_div(op_q) & ((rs2_p == '0) | ovf);
  end

  // FIX: opnd_q holds |rs2| for divides, so zero means divide-by-zero
  always_comb begin : fix_c
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    dz      = (opnd_q == '0);
    res_fix = '0;
    unique case (1'b1)
      fast_q & dz:
        res_fix = md_is_rem(op_q) ? a_q : '1;
      fast_q & ~dz:
        res_fix = md_is_rem(op_q) ? '0 : a_q;
      ~fast_q & ~md_is_div(op_q):
        res_fix = (op_q == MD_MUL) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];
      default:
        res_fix = md_is_rem(op_q) ? rem : quo;
    endcase
  end

  always_comb begin : next_c
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = MD_PREP;
      MD_PREP: state_d = prep_fast ? MD_FIX : MD_CALC;
      MD_CALC: if (cnt_q == CW'(1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i && state_q != MD_IDLE) state_d = MD_IDLE;
  end

  always_comb begin : data_c
    op_d   = op_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    a_d    = a_q;
    res_d  = res_q;
    neg_d  = neg_q;
    fast_d = fast_q;
    cnt_d  = cnt_q;
    tag_d  = tag_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d  = muldiv_op_e'(op_i);
          acc_d = {rs1_data_i, rs2_data_i};
          a_d   = rs1_data_i;
          tag_d = rd_adr_i;
        end
      end
      MD_PREP: begin
        cnt_d  = CW'(NSTEP);
        fast_d = prep_fast;
        if (md_is_div(op_q)) begin
          opnd_d = abs2;
          acc_d  = {{XLEN{1'b0}}, abs1};
        end else begin
          opnd_d = abs1;
          acc_d  = {{XLEN{1'b0}}, abs2};
        end
        // remainder follows the dividend; everything else is a xor
        neg_d = md_is_rem(op_q) ? neg1 : (neg1 ^ neg2);
      end
      MD_CALC: begin
        acc_d = chain[UNROLL];
        cnt_d = cnt_q - CW'(1);
      end
      MD_FIX: res_d = res_fix;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= MD_MUL;
      acc_q  <= '0;
      opnd_q <= '0;
      a_q    <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      fast_q <= 1'b0;
      cnt_q  <= '0;
      tag_q  <= '0;
    end else begin
      op_q   <= op_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      a_q    <= a_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      fast_q <= fast_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin : out_c
    ready_o      = (state_q == MD_IDLE) & ~reset;
    busy_o       = ~ready_o;
    res_v_o      = (state_q == MD_DONE) & ~flush_i & ~reset;
    res_data_o   = res_v_o ? res_q : '0;
    res_rd_adr_o = (state_q == MD_IDLE || reset) ? '0 : tag_q;
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: random and directed checks of exe_muldiv against a
// plain-arithmetic RV32M model, with UNROLL=1 and UNROLL=4 instances.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_adr_i;
  logic        ready_o, busy_o, res_v_o;
  logic [31:0] res_data_o;
  logic [4:0]  res_rd_adr_o;

  logic        start4, flush4;
  logic [2:0]  op4;
  logic [31:0] a4, b4;
  logic [4:0]  rd4;
  logic        ready4, busy4, resv4;
  logic [31:0] resd4;
  logic [4:0]  rtag4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(32), .UNROLL(1)) u_dut (
    .clk(clk), .reset(reset), .start_v_i(start_v_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rd_adr_i(rd_adr_i), .flush_i(flush_i), .ready_o(ready_o),
    .busy_o(busy_o), .res_v_o(res_v_o), .res_data_o(res_data_o),
    .res_rd_adr_o(res_rd_adr_o)
  );

  exe_muldiv #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset), .start_v_i(start4), .op_i(op4),
    .rs1_data_i(a4), .rs2_data_i(b4), .rd_adr_i(rd4),
    .flush_i(flush4), .ready_o(ready4), .busy_o(busy4),
    .res_v_o(resv4), .res_data_o(resd4), .res_rd_adr_o(rtag4)
  );

  // Reference: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    int qa, qb;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    pu  = {32'b0, a} * {32'b0, b};
    qa  = $signed(a);
    qb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return qa / qb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return qa % qb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int unroll);
    logic sdiv;
    sdiv = (op == 3'd4) || (op == 3'd6);
    if (op[2] && (b == 0 || (sdiv && a == 32'h8000_0000 && b == '1)))
      return 3;
    return 32 / unroll + 3;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic rv(input bit s);
    return s ? resv4 : res_v_o;
  endfunction
  function automatic logic [31:0] rd(input bit s);
    return s ? resd4 : res_data_o;
  endfunction
  function automatic logic [4:0] rt(input bit s);
    return s ? rtag4 : res_rd_adr_o;
  endfunction
  function automatic logic rdy(input bit s);
    return s ? ready4 : ready_o;
  endfunction

  task automatic drv(input bit s, input logic v, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] t);
    if (s) begin
      start4 = v; op4 = op; a4 = a; b4 = b; rd4 = t;
    end else begin
      start_v_i = v; op_i = op; rs1_data_i = a; rs2_data_i = b;
      rd_adr_i = t;
    end
  endtask

  task automatic fl(input bit s, input logic v);
    if (s) flush4 = v;
    else   flush_i = v;
  endtask

  // Issues one request (entered just after a negedge) and observes it.
  // Cycle c is sampled on the c-th negedge after the accepting edge.
  task automatic issue(input bit s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int poke_c,
                       input int kill_c, input bit kill_rst,
                       output int lat, output logic [31:0] data,
                       output logic [4:0] rtag, output int pulses,
                       output logic rdy_end, output logic rdy_kill,
                       output int leak);
    lat = -1; data = '0; rtag = '0; pulses = 0; leak = 0;
    rdy_end = 1'bx; rdy_kill = 1'bx;
    drv(s, 1'b1, op, a, b, tag);
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1 || c == poke_c + 1) drv(s, 1'b0, op, a, b, tag);
      if (c == poke_c) drv(s, 1'b1, ~op, ~a, b, ~tag);
      if (kill_c > 0 && c == kill_c) begin
        if (kill_rst) reset = 1'b1;
        else          fl(s, 1'b1);
      end
      if (kill_c > 0 && c == kill_c + 1) begin
        reset = 1'b0;
        fl(s, 1'b0);
        #1;
        rdy_end = rdy(s);
        break;
      end
      #1;
      if (kill_c > 0 && c == kill_c) rdy_kill = rdy(s);
      if (rv(s)) begin
        pulses++;
        if (lat < 0) begin
          lat = c; data = rd(s); rtag = rt(s);
        end
      end else if (rd(s) !== '0) begin
        leak++;
      end
      if (lat > 0 && c == lat + 1) begin
        rdy_end = rdy(s);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(0, 1'b1, 3'd0, 32'd3, 32'd4, 5'd7);
    drv(1, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    flush_i = 1'b0; flush4 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b want 0", ready_o);
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_busy got %b want 1", busy_o);
    end
    checks++;
    if (res_v_o !== 1'b0) begin
      errors++; $display("FAIL rst_res_v got %b want 0", res_v_o);
    end
    checks++;
    if (res_data_o !== 32'd0) begin
      errors++; $display("FAIL rst_data got %h want 0", res_data_o);
    end
    checks++;
    if (res_rd_adr_o !== 5'd0) begin
      errors++; $display("FAIL rst_tag got %0d want 0", res_rd_adr_o);
    end
    @(negedge clk);
    reset = 1'b0;
    start_v_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_ready got %b/%b want 1/0", ready_o, busy_o);
    end
    checks++;
    if (ready4 !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready4 got %b want 1", ready4);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  dop [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                              3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] da  [12] = '{32'd7, '1, '1, '1, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] db  [12] = '{32'hFFFF_FFFD, '1, '1, '1, 32'd2, 32'd2,
                              32'd0, 32'd0, '1, '1, 32'd0, 32'd0};
    logic [31:0] dr  [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd0, '1,
                              32'hFFFF_FFFD, '1, '1, 32'd5,
                              32'h8000_0000, 32'd0, '1, 32'hFFFF_FFF9};
    int          dl  [12] = '{35, 35, 35, 35, 35, 35, 3, 3, 3, 3, 3, 3};
    int lat, pul, lk;
    logic [31:0] d;
    logic [4:0] t;
    logic re, rk;
    for (int i = 0; i < 12; i++) begin
      issue(0, dop[i], da[i], db[i], 5'(i + 1), 0, 0, 0,
            lat, d, t, pul, re, rk, lk);
      checks++;
      if (lat !== dl[i]) begin
        errors++; $display("FAIL dir%0d lat got %0d want %0d", i, lat, dl[i]);
      end
      checks++;
      if (d !== dr[i]) begin
        errors++; $display("FAIL dir%0d data got %h want %h", i, d, dr[i]);
      end
      checks++;
      if (t !== 5'(i + 1)) begin
        errors++; $display("FAIL dir%0d tag got %0d want %0d", i, t, i + 1);
      end
    end
  endtask

  task automatic test_random(input bit s, input int n, input int unroll);
    int lat, pul, lk, el;
    logic [31:0] a, b, d, er;
    logic [2:0] op;
    logic [4:0] tag, t;
    logic re, rk;
    for (int i = 0; i < n; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick();
      b   = pick();
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000; b = '1;
      end
      tag = 5'($urandom_range(1, 31));
      er  = ref_md(op, a, b);
      el  = ref_lat(op, a, b, unroll);
      issue(s, op, a, b, tag, 0, 0, 0, lat, d, t, pul, re, rk, lk);
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL rnd%0d_u%0d lat op%0d got %0d want %0d",
                 i, unroll, op, lat, el);
      end
      checks++;
      if (d !== er) begin
        errors++;
        $display("FAIL rnd%0d_u%0d data op%0d %h,%h got %h want %h",
                 i, unroll, op, a, b, d, er);
      end
      checks++;
      if (t !== tag) begin
        errors++; $display("FAIL rnd%0d tag got %0d want %0d", i, t, tag);
      end
      checks++;
      if (pul !== 1) begin
        errors++; $display("FAIL rnd%0d pulses got %0d want 1", i, pul);
      end
      checks++;
      if (re !== 1'b1) begin
        errors++; $display("FAIL rnd%0d ready_after got %b want 1", i, re);
      end
      checks++;
      if (lk !== 0) begin
        errors++; $display("FAIL rnd%0d data_leak got %0d want 0", i, lk);
      end
    end
  endtask

  task automatic test_flush();
    int lat, pul, lk;
    logic [31:0] d;
    logic [4:0] t;
    logic re, rk;
    issue(0, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 0, 10, 0,
          lat, d, t, pul, re, rk, lk);
    checks++;
    if (pul !== 0) begin
      errors++; $display("FAIL flush_res_v got %0d pulses want 0", pul);
    end
    checks++;
    if (re !== 1'b1) begin
      errors++; $display("FAIL flush_ready got %b want 1", re);
    end
    issue(0, 3'd4, 32'd1000, 32'd7, 5'd12, 0, 0, 0,
          lat, d, t, pul, re, rk, lk);
    checks++;
    if (lat !== 35 || d !== 32'd142 || t !== 5'd12) begin
      errors++;
      $display("FAIL flush_restart got lat%0d %h tag%0d want lat35 8e tag12",
               lat, d, t);
    end
  endtask

  task automatic test_flush_idle();
    int seen = 0;
    drv(0, 1'b1, 3'd0, 32'd3, 32'd4, 5'd9);
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b0, 3'd0, 32'd3, 32'd4, 5'd9);
    flush_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_idle_ready got %b want 1", ready_o);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_v_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_idle_res got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pul, lk;
    logic [31:0] d;
    logic [4:0] t;
    logic re, rk;
    issue(0, 3'd0, 32'd123, 32'd456, 5'd14, 0, 5, 1,
          lat, d, t, pul, re, rk, lk);
    checks++;
    if (rk !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready_in_rst got %b want 0", rk);
    end
    checks++;
    if (pul !== 0) begin
      errors++; $display("FAIL rstmid_res_v got %0d pulses want 0", pul);
    end
    checks++;
    if (re !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b want 1", re);
    end
    issue(0, 3'd7, 32'd1000, 32'd7, 5'd13, 0, 0, 0,
          lat, d, t, pul, re, rk, lk);
    checks++;
    if (lat !== 35 || d !== 32'd6 || t !== 5'd13) begin
      errors++;
      $display("FAIL rstmid_restart got lat%0d %h tag%0d want lat35 6 tag13",
               lat, d, t);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  bop [3] = '{3'd0, 3'd5, 3'd3};
    logic [31:0] ba  [3] = '{32'd3, 32'd50, 32'h0001_0000};
    logic [31:0] bb  [3] = '{32'd5, 32'd5, 32'h0001_0000};
    logic [31:0] br  [3] = '{32'd15, 32'd10, 32'd1};
    int lat, pul, lk;
    logic [31:0] d;
    logic [4:0] t;
    logic re, rk;
    for (int i = 0; i < 3; i++) begin
      issue(0, bop[i], ba[i], bb[i], 5'(21 + i), 5, 0, 0,
            lat, d, t, pul, re, rk, lk);
      checks++;
      if (d !== br[i] || lat !== 35) begin
        errors++;
        $display("FAIL b2b%0d got %h lat%0d want %h lat35", i, d, lat, br[i]);
      end
      checks++;
      if (t !== 5'(21 + i)) begin
        errors++; $display("FAIL b2b%0d tag got %0d want %0d", i, t, 21 + i);
      end
    end
  endtask

  task automatic test_unroll4();
    int lat, pul, lk;
    logic [31:0] d;
    logic [4:0] t;
    logic re, rk;
    issue(1, 3'd5, 32'd100, 32'd7, 5'd3, 0, 0, 0,
          lat, d, t, pul, re, rk, lk);
    checks++;
    if (lat !== 11 || d !== 32'd14) begin
      errors++; $display("FAIL u4_divu got %0d lat%0d want 14 lat11", d, lat);
    end
    issue(1, 3'd7, 32'd100, 32'd7, 5'd4, 0, 0, 0,
          lat, d, t, pul, re, rk, lk);
    checks++;
    if (lat !== 11 || d !== 32'd2) begin
      errors++; $display("FAIL u4_remu got %0d lat%0d want 2 lat11", d, lat);
    end
    test_random(1, 12, 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random(0, 40, 1);
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_back_to_back();
    test_unroll4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter UNROLL, default 1: iteration steps per CALC cycle; legal values 1, 2, 4; must divide XLEN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start_v_i  input  1  request valid; accepted only when ready_o=1.
REQ-006 op_i  input  3  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (RV32M funct3 encoding).
REQ-007 rs1_data_i  input  XLEN  dividend / multiplicand.
REQ-008 rs2_data_i  input  XLEN  divisor / multiplier.
REQ-009 rd_adr_i  input  5  destination register tag.
REQ-010 flush_i  input  1  cancel the in-flight operation (branch taken).
REQ-011 ready_o  output  1  unit idle and able to accept start_v_i.
REQ-012 busy_o  output  1  stall request to decode; equals ~ready_o.
REQ-013 res_v_o  output  1  result valid, single-cycle pulse.
REQ-014 res_data_o  output  XLEN  result; 0 when res_v_o=0.
REQ-015 res_rd_adr_o  output  5  tag captured at accept.

Function
REQ-016 FSM states: IDLE, PREP, CALC, FIX, DONE.
REQ-017 IDLE: ready_o=1; start_v_i=1 and flush_i=0 latches op, operands and tag, then goes to PREP.
REQ-018 PREP, 1 cycle: takes operand absolute values per signedness, records result sign, and loads the iteration counter with XLEN/UNROLL.
REQ-019 PREP fast path: division with rs2=0, or signed DIV/REM with rs1=most-negative and rs2=-1, goes to FIX and skips CALC.
REQ-020 CALC: performs UNROLL shift-add (multiply) or restoring-subtract (divide) steps per cycle, decrements the counter, and goes to FIX when the counter reaches 1.
REQ-021 FIX, 1 cycle: applies sign correction, selects the low or high product half (or quotient/remainder), and registers the result.
REQ-022 DONE: res_v_o = ~flush_i for exactly one cycle, then IDLE.
REQ-023 Latency: accept at edge T gives res_v_o in cycle T+XLEN/UNROLL+3; the fast path gives res_v_o in cycle T+3.
REQ-024 Arithmetic: 2*XLEN-bit product internally.
REQ-025 Multiply results: MUL returns the low half; MULH is signed×signed high half; MULHSU is signed rs1 × unsigned rs2 high half; MULHU is unsigned high half.
REQ-026 Division truncates toward zero; the remainder takes the dividend's sign.
REQ-027 Divide by zero: quotient is all-ones, remainder is rs1.
REQ-028 Signed overflow: quotient is rs1, remainder is 0.
REQ-029 flush_i in PREP/CALC/FIX: next state IDLE, no res_v_o, datapath registers do not care.
REQ-030 flush_i in IDLE with start_v_i: the request is dropped.
REQ-031 start_v_i while ready_o=0 is ignored; there is no buffering, and the requester holds until accepted.
REQ-032 res_rd_adr_o is stable from FIX through DONE; it is 0 in IDLE.

Reset
REQ-033 reset=1 forces state IDLE, counter 0, and all registered data/tag to 0, regardless of the current state.
REQ-034 During reset: ready_o=0, busy_o=1, res_v_o=0, res_data_o=0, res_rd_adr_o=0.
REQ-035 In the first cycle after reset deasserts: ready_o=1.

Structure
REQ-036 riscv_pkg SHALL hold the muldiv_op_e enum (8 funct3 encodings) and the muldiv_state_e enum.
REQ-037 riscv_pkg SHALL hold the NB_UNIT/unit index for MULDIV so decode can route operations.
REQ-038 One sub-module, muldiv_step: combinational single iteration (add-shift or restore-subtract), instantiated UNROLL times in a chain.
REQ-039 exe_muldiv contains no other sub-modules.

Verification
REQ-040 XLEN=32, UNROLL=1: MUL 7 × 0xFFFFFFFD -> res_data_o=0xFFFFFFEB in cycle T+35; rd tag echoed.
REQ-041 Operands 0xFFFFFFFF × 0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-042 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; both at T+35.
REQ-043 Divide-by-zero fast path, each at T+3:
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
REQ-044 Signed-overflow fast path, each at T+3:
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM 0x80000000/0xFFFFFFFF -> 0.
REQ-045 Flush and reset mid-operation:
- flush_i at T+10 -> no res_v_o; ready_o=1 at T+11; a start issued at T+11 completes normally.
- reset at T+5 -> same outcome.
REQ-046 UNROLL=4: DIVU 100/7 -> 14 in cycle T+11; REMU 100/7 -> 2.
